// File: rtl/tx_buffer.sv
// tx_buffer: transmit byte FIFO that launches one frame at a time into tx_frontend
module tx_buffer #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    clear_i,
  input  logic                    enable_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o,
  output logic                    idle_o,
  output logic                    transmit_o,
  output logic [DATA_WIDTH-1:0]   dr_o,
  input  logic                    done_i
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic push_ok, launch;
  // Fill status from registered pointers; the extra MSB separates full from empty
  always_comb begin
    level_o = wr_ptr - rd_ptr;
    full_o  = level_o == (AW+1)'(DEPTH);
    empty_o = wr_ptr == rd_ptr;
    idle_o  = (state == IDLE) && empty_o;
    push_ok = push_i && !full_o && !clear_i;
    launch  = (state == IDLE) && enable_i && !empty_o && !clear_i;
  end
  // Next state: launch moves to WAIT_DONE, done pulse returns to IDLE
  always_comb begin
    state_nx = launch ? WAIT_DONE : (state == WAIT_DONE && done_i) ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  end
  // Pointers: clear discards everything queued by snapping read to write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (clear_i) rd_ptr <= wr_ptr;
      else if (launch) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // Storage array, written only on accepted pushes
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end
  // Registered launch pulse, held data byte and overflow pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      transmit_o <= 1'b0;
      dr_o       <= '0;
      overflow_o <= 1'b0;
    end else begin
      transmit_o <= launch;
      dr_o       <= launch ? mem[rd_ptr[AW-1:0]] : dr_o;
      overflow_o <= push_i && full_o && !clear_i;
    end
  end
endmodule

// File: tb/tb_tx_buffer.sv
// tb_tx_buffer: directed scoreboard bench for tx_buffer
module tb_tx_buffer;
  logic clk = 1'b0;
  logic rst, push, clear, enable, done;
  logic [7:0] wdata;
  logic full, empty, overflow, idle, transmit;
  logic [4:0] level;
  logic [7:0] dr;
  int vecs = 0;
  int errs = 0;
  logic tx_seen;
  logic [7:0] exp_q[$];
  tx_buffer #(.DEPTH(16), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .wdata_i(wdata), .clear_i(clear),
    .enable_i(enable), .full_o(full), .empty_o(empty), .level_o(level),
    .overflow_o(overflow), .idle_o(idle), .transmit_o(transmit), .dr_o(dr), .done_i(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    tx_seen = transmit;
    if (transmit === 1'b1) begin
      if (exp_q.size() == 0) chk("tx_spurious", {31'd0, transmit}, 32'd0);
      else chk("tx_data", {24'd0, dr}, {24'd0, exp_q.pop_front()});
    end
  endtask
  task automatic push_byte(input logic [7:0] b, input bit accept);
    push = 1'b1;
    wdata = b;
    if (accept) exp_q.push_back(b);
    tick();
    push = 1'b0;
  endtask
  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask
  task automatic wait_pulse();
    int n;
    n = 0;
    tick();
    while (!tx_seen && n < 60) begin
      tick();
      n++;
    end
    chk("tx_timeout", {31'd0, tx_seen}, 32'd1);
  endtask
  initial begin
    rst = 1'b1; push = 1'b0; clear = 1'b0; enable = 1'b0; done = 1'b0; wdata = 8'h00;
    tick();
    tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_transmit", {31'd0, transmit}, 32'd0);
    chk("rst_dr", {24'd0, dr}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    rst = 1'b0;
    enable = 1'b1;
    push_byte(8'hA5, 1'b1);
    chk("single_n1_tx", {31'd0, transmit}, 32'd0);
    chk("single_n1_empty", {31'd0, empty}, 32'd0);
    chk("single_n1_level", {27'd0, level}, 32'd1);
    tick();
    chk("single_n2_tx", {31'd0, transmit}, 32'd1);
    chk("single_n2_level", {27'd0, level}, 32'd0);
    repeat (6) begin
      tick();
      chk("single_no_repeat", {31'd0, transmit}, 32'd0);
    end
    chk("single_busy", {31'd0, idle}, 32'd0);
    pulse_done();
    chk("single_idle", {31'd0, idle}, 32'd1);
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    chk("order_first_tx", {31'd0, transmit}, 32'd1);
    push_byte(8'h33, 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (i == 0 ? 38 : 39) tick();
      pulse_done();
      chk("order_gap1", {31'd0, transmit}, 32'd0);
      if (i < 2) begin
        tick();
        chk("order_gap2", {31'd0, transmit}, 32'd1);
      end
    end
    chk("order_idle", {31'd0, idle}, 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_level16", {27'd0, level}, 32'd16);
    push_byte(8'hFF, 1'b0);
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("ovf_level_hold", {27'd0, level}, 32'd16);
    tick();
    chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    enable = 1'b1;
    push_byte(8'h77, 1'b0);
    chk("fl_overflow", {31'd0, overflow}, 32'd1);
    chk("fl_level15", {27'd0, level}, 32'd15);
    chk("fl_launch", {31'd0, transmit}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) wait_pulse();
      repeat (3) tick();
      pulse_done();
    end
    chk("drain_idle", {31'd0, idle}, 32'd1);
    chk("drain_sb_empty", exp_q.size(), 32'd0);
    push_byte(8'h50, 1'b1);
    wait_pulse();
    for (int i = 1; i <= 5; i++) push_byte(8'(8'h50 + i), 1'b0);
    chk("clr_level5", {27'd0, level}, 32'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_level0", {27'd0, level}, 32'd0);
    chk("clr_empty", {31'd0, empty}, 32'd1);
    repeat (5) begin
      tick();
      chk("clr_no_tx", {31'd0, transmit}, 32'd0);
    end
    chk("clr_busy", {31'd0, idle}, 32'd0);
    pulse_done();
    chk("clr_idle", {31'd0, idle}, 32'd1);
    push_byte(8'h3C, 1'b1);
    wait_pulse();
    pulse_done();
    chk("final_idle", {31'd0, idle}, 32'd1);
    chk("final_sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
